// File: rtl/cdr_param_pkg.sv
// rtl/cdr_param_pkg.sv - shared widths, state type and sample-point helper for the parametrised CDR
package cdr_param_pkg;

   typedef enum logic {
      ACQ    = 1'b0,
      LOCKED = 1'b1
   } cdr_state_e;

   // Bits needed to hold any value in 0 .. n-1 (at least one bit).
   function automatic int count_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Signed timing error spans -OSR/2 .. OSR/2-1, so one extra bit over the counter.
   function automatic int err_width(input int osr);
      return $clog2(osr) + 1;
   endfunction

   function automatic int sample_point(input int osr);
      return osr / 2;
   endfunction

endpackage

// File: rtl/phase_discriminator.sv
// rtl/phase_discriminator.sv - wrapped phase difference to raw bit, with first-sample suppression
module phase_discriminator #(
   parameter int PHASE_W = 6
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [PHASE_W-1:0] phase_i,
   input  logic               ph_valid_i,
   output logic               raw_o,
   output logic               v1_o
);

   logic [PHASE_W-1:0] phase_q;
   logic [PHASE_W-1:0] dphi;
   logic               first_q;

   // Modular subtraction: the wrap of the phase accumulator falls out for free.
   assign dphi = phase_i - phase_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         phase_q <= '0;
         first_q <= 1'b1;
         raw_o   <= 1'b0;
         v1_o    <= 1'b0;
      end else begin
         v1_o <= ph_valid_i && !first_q;
         if (ph_valid_i) begin
            phase_q <= phase_i;
            first_q <= 1'b0;
            if (!first_q) begin
               if (dphi[PHASE_W-1])
                  raw_o <= 1'b0;
               else if (dphi != '0)
                  raw_o <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/bit_recovery_cdr_param.sv
// rtl/bit_recovery_cdr_param.sv - oversampling CDR with early/late correction, fast acquisition and lock tracking
module bit_recovery_cdr_param
   import cdr_param_pkg::*;
#(
   parameter int PHASE_W  = 6,
   parameter int OSR      = 8,
   parameter int LOCK_TOL = 1,
   parameter int LOCK_CNT = 16,
   parameter int MAX_RUN  = 8
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [PHASE_W-1:0] phase_i,
   input  logic               ph_valid_i,
   output logic               data_o,
   output logic               data_en_o,
   output logic               lock_o
);

   localparam int CNT_W = count_width(OSR);
   localparam int ERR_W = err_width(OSR);
   localparam int LC_W  = count_width(LOCK_CNT + 1);
   localparam int RUN_W = count_width(MAX_RUN + 2);
   localparam int SP    = sample_point(OSR);
   localparam logic [LC_W-1:0]  LC_MAX  = LC_W'(LOCK_CNT);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RUN + 1);

   typedef logic signed [ERR_W-1:0] err_t;

   logic raw;
   logic v1;

   phase_discriminator #(
      .PHASE_W (PHASE_W)
   ) u_disc (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .phase_i    (phase_i),
      .ph_valid_i (ph_valid_i),
      .raw_o      (raw),
      .v1_o       (v1)
   );

   cdr_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [LC_W-1:0]  lock_cnt_q, lock_cnt_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             raw_prev_q, raw_prev_d;
   logic             emit;
   logic             transition;
   logic             in_win;
   err_t             err;
   int               c_cur, c_nxt, e_int;

   assign c_cur      = int'(cnt_q);
   assign err        = (c_cur < SP) ? err_t'(c_cur) : err_t'(c_cur - OSR);
   assign e_int      = int'(err);
   assign in_win     = (e_int <= LOCK_TOL) && (e_int >= -LOCK_TOL);
   assign transition = (raw != raw_prev_q);
   assign lock_o     = (state_q == LOCKED);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lock_cnt_d = lock_cnt_q;
      run_d      = run_q;
      raw_prev_d = raw_prev_q;
      emit       = 1'b0;
      c_nxt      = c_cur;
      if (v1) begin
         raw_prev_d = raw;
         // Before lock every edge realigns hard; once locked only nudge by one sample.
         if (!transition)
            c_nxt = (c_cur + 1) % OSR;
         else if (state_q == ACQ)
            c_nxt = 1;
         else if (e_int > 0)
            c_nxt = c_cur;
         else if (e_int < 0 && c_cur >= SP + 1)
            c_nxt = (c_cur + 2) % OSR;
         else
            c_nxt = (c_cur + 1) % OSR;
         cnt_d = CNT_W'(c_nxt);
         emit  = (c_nxt == SP);
         if (transition) begin
            run_d = '0;
            if (in_win) begin
               if (lock_cnt_q != LC_MAX)
                  lock_cnt_d = lock_cnt_q + 1'b1;
               if (lock_cnt_d == LC_MAX)
                  state_d = LOCKED;
            end else begin
               lock_cnt_d = '0;
               state_d    = ACQ;
            end
         end else if (emit) begin
            if (run_q != RUN_MAX)
               run_d = run_q + 1'b1;
            if (run_d == RUN_MAX) begin
               lock_cnt_d = '0;
               state_d    = ACQ;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= ACQ;
         cnt_q      <= '0;
         lock_cnt_q <= '0;
         run_q      <= '0;
         raw_prev_q <= 1'b0;
         data_o     <= 1'b0;
         data_en_o  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lock_cnt_q <= lock_cnt_d;
         run_q      <= run_d;
         raw_prev_q <= raw_prev_d;
         data_en_o  <= emit;
         if (emit)
            data_o <= raw;
      end
   end

endmodule

// File: tb/tb_bit_recovery_cdr_param.sv
// tb/tb_bit_recovery_cdr_param.sv - directed-vector bench for the parametrised CDR
module tb_bit_recovery_cdr_param;

   localparam int PW  = 6;
   localparam int OSR = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ph_valid = 1'b0;
   logic [PW-1:0] phase = '0;
   logic          data, data_en, lock;

   always #5 clk = ~clk;

   bit_recovery_cdr_param #(
      .PHASE_W  (PW),
      .OSR      (OSR),
      .LOCK_TOL (1),
      .LOCK_CNT (16),
      .MAX_RUN  (8)
   ) dut (
      .clk_i      (clk),
      .reset_i    (rst),
      .phase_i    (phase),
      .ph_valid_i (ph_valid),
      .data_o     (data),
      .data_en_o  (data_en),
      .lock_o     (lock)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Strobe log: sample index travels two cycles alongside the DUT latency.
   int cur_idx = -1;
   int vd1 = -1;
   int vd2 = -1;
   int cyc = 0;
   int st_idx[$];
   int st_dat[$];
   int st_cyc[$];
   int lock_at[0:300];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      vd1 <= ph_valid ? cur_idx : -1;
      vd2 <= vd1;
   end

   always @(negedge clk) begin
      if (data_en) begin
         st_idx.push_back(vd2);
         st_dat.push_back(int'(data));
         st_cyc.push_back(cyc);
      end
      if (vd2 >= 0 && vd2 <= 300)
         lock_at[vd2] = int'(lock);
   end

   task automatic clear_log();
      st_idx.delete();
      st_dat.delete();
      st_cyc.delete();
      for (int i = 0; i <= 300; i++)
         lock_at[i] = -1;
   endtask

   task automatic feed(input logic [PW-1:0] ph, input int idx, input int gap);
      phase    = ph;
      cur_idx  = idx;
      ph_valid = 1'b1;
      @(negedge clk);
      ph_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_log();
   endtask

   task automatic check_strobes(input string tag, input int ei[$], input int ed[$]);
      check({tag, "_count"}, st_idx.size(), ei.size());
      for (int i = 0; i < ei.size() && i < st_idx.size(); i++) begin
         check($sformatf("%s_idx%0d", tag, i), st_idx[i], ei[i]);
         check($sformatf("%s_dat%0d", tag, i), st_dat[i], ed[i]);
      end
   endtask

   logic [PW-1:0] main_ph[0:260];
   int            bit_len[0:22];
   int            ei[$];
   int            ed[$];

   initial begin
      logic [PW-1:0] p;
      int j;

      // Alternating bits of 8 samples, one 9-sample bit, then an 83-sample run of ones.
      for (int b = 0; b <= 22; b++) bit_len[b] = 8;
      bit_len[17] = 9;
      bit_len[20] = 83;
      p = '0;
      main_ph[0] = p;
      j = 1;
      for (int b = 0; b <= 22; b++) begin
         for (int k = 0; k < bit_len[b]; k++) begin
            p = (b % 2 == 0) ? p + PW'(4) : p - PW'(4);
            main_ph[j] = p;
            j++;
         end
      end

      #3;
      check("rst_data", int'(data), 0);
      check("rst_data_en", int'(data_en), 0);
      check("rst_lock", int'(lock), 0);
      do_reset();

      // Acquisition, lock, late edge, long run and reacquisition in one stream.
      for (int i = 0; i <= 260; i++) feed(main_ph[i], i, 0);
      repeat (4) @(negedge clk);
      ei.delete(); ed.delete();
      for (int b = 0; b <= 16; b++) begin
         ei.push_back(4 + 8 * b);
         ed.push_back((b % 2 == 0) ? 1 : 0);
      end
      ei.push_back(140); ed.push_back(0);
      ei.push_back(149); ed.push_back(1);
      ei.push_back(157); ed.push_back(0);
      for (int m = 0; m < 10; m++) begin
         ei.push_back(165 + 8 * m);
         ed.push_back(1);
      end
      ei.push_back(248); ed.push_back(0);
      ei.push_back(256); ed.push_back(1);
      check_strobes("main", ei, ed);
      check("lock_before_16th", lock_at[120], 0);
      check("lock_at_16th", lock_at[121], 1);
      check("lock_after_late", lock_at[160], 1);
      check("lock_run8", lock_at[228], 1);
      check("lock_run9_drop", lock_at[229], 0);
      check("lock_reacq", lock_at[250], 0);

      // Ramp across the signed wrap: no spurious edges.
      do_reset();
      for (int i = 0; i <= 24; i++) feed(PW'(28 + 3 * i), i, 0);
      repeat (4) @(negedge clk);
      ei = '{4, 12, 20};
      ed = '{1, 1, 1};
      check_strobes("wrap", ei, ed);

      // Valid every third cycle.
      do_reset();
      for (int i = 0; i <= 40; i++) feed(main_ph[i], i, 2);
      repeat (8) @(negedge clk);
      ei = '{4, 12, 20, 28, 36};
      ed = '{1, 0, 1, 0, 1};
      check_strobes("gap", ei, ed);
      for (int i = 1; i < st_cyc.size(); i++)
         check($sformatf("gap_space%0d", i), st_cyc[i] - st_cyc[i-1], 3 * OSR);

      // Reset while locked, mid-bit.
      do_reset();
      for (int i = 0; i <= 134; i++) feed(main_ph[i], i, 0);
      check("pre_rst_data", int'(data), 1);
      check("pre_rst_lock", int'(lock), 1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_data", int'(data), 0);
      check("mid_rst_data_en", int'(data_en), 0);
      check("mid_rst_lock", int'(lock), 0);
      clear_log();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i <= 12; i++) feed(PW'(20 + 4 * i), i, 0);
      repeat (4) @(negedge clk);
      ei = '{4, 12};
      ed = '{1, 1};
      check_strobes("reacq", ei, ed);
      check("reacq_lock", lock_at[12], 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
